// File: rtl/os_pkg.sv
// Shared types for the output-stationary result drain: FSM state encoding and
// the row-index width helper used for port sizing.
package os_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STREAM  = 2'd2,
      ST_DONE    = 2'd3
   } os_drain_state_t;

   function automatic int idx_width(input int n_rows);
      return (n_rows < 2) ? 1 : $clog2(n_rows);
   endfunction

endpackage

// File: rtl/os_edge_detect.sv
// Registers the array's level done flag and flags its rising edge.
// The register runs every cycle, independent of any soft abort.
module os_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_level_q,
   output logic o_rise
);

   logic r_level_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_level_q <= 1'b0;
      else          r_level_q <= i_level;
   end

   assign o_level_q = r_level_q;
   assign o_rise    = i_level && !r_level_q;

endmodule

// File: rtl/os_result_drain.sv
// Captures the flattened result matrix on a done rise and streams it out one
// row per valid/ready beat, pulsing done after the last row.
module os_result_drain
   import os_pkg::*;
#(
   parameter int rows     = 64,
   parameter int cols     = 64,
   parameter int op_width = 48
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clr,
   input  logic                            compute_done,
   input  logic [31:0]                     cycles_count,
   input  logic [rows*cols*op_width-1:0]   output_matrix,
   output logic                            row_valid,
   input  logic                            row_ready,
   output logic [cols*op_width-1:0]        row_data,
   output logic [idx_width(rows)-1:0]      row_idx,
   output logic                            row_last,
   output logic                            busy,
   output logic                            done,
   output logic [31:0]                     cycles_latched,
   output logic                            overrun,
   output os_drain_state_t                 dbg_state
);

   localparam int IW    = idx_width(rows);
   localparam int ROW_W = cols * op_width;
   localparam logic [IW-1:0] LAST_IDX = IW'(rows - 1);

   // Handshake: a beat transfers on a rising edge where row_valid && row_ready;
   // while valid is high and ready low, row_data and row_idx hold unchanged.

   logic                          w_rise;
   logic                          w_done_q;
   os_drain_state_t               r_state;
   logic [rows*cols*op_width-1:0] r_capture;
   logic [31:0]                   r_cycles;
   logic [IW-1:0]                 r_row_idx;
   logic                          r_overrun;

   os_edge_detect u_edge (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_level   (compute_done),
      .o_level_q (w_done_q),
      .o_rise    (w_rise)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_capture <= '0;
         r_cycles  <= '0;
         r_row_idx <= '0;
         r_overrun <= 1'b0;
      end else if (clr) begin
         // Abort wins over a simultaneous rise; no capture happens this cycle.
         r_state   <= ST_IDLE;
         r_row_idx <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_rise && (r_state != ST_IDLE)) r_overrun <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_capture <= output_matrix;
                  r_cycles  <= cycles_count;
                  r_state   <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               r_row_idx <= '0;
               r_state   <= ST_STREAM;
            end
            ST_STREAM: begin
               if (row_ready) begin
                  if (r_row_idx == LAST_IDX) r_state <= ST_DONE;
                  else                       r_row_idx <= r_row_idx + 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign row_valid      = (r_state == ST_STREAM);
   assign row_data       = r_capture[int'(r_row_idx)*ROW_W +: ROW_W];
   assign row_idx        = r_row_idx;
   assign row_last       = row_valid && (r_row_idx == LAST_IDX);
   assign busy           = (r_state != ST_IDLE);
   assign done           = (r_state == ST_DONE);
   assign cycles_latched = r_cycles;
   assign overrun        = r_overrun;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_os_result_drain.sv
// Directed bench for os_result_drain at rows=4, cols=4, op_width=16.
module tb_os_result_drain;
  import os_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int OPW  = 16;

  logic                       clk;
  logic                       rst;
  logic                       clr;
  logic                       compute_done;
  logic [31:0]                cycles_count;
  logic [ROWS*COLS*OPW-1:0]   output_matrix;
  logic                       row_valid;
  logic                       row_ready;
  logic [COLS*OPW-1:0]        row_data;
  logic [1:0]                 row_idx;
  logic                       row_last;
  logic                       busy;
  logic                       done;
  logic [31:0]                cycles_latched;
  logic                       overrun;
  os_drain_state_t            dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  os_result_drain #(.rows(ROWS), .cols(COLS), .op_width(OPW)) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .compute_done   (compute_done),
    .cycles_count   (cycles_count),
    .output_matrix  (output_matrix),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .row_data       (row_data),
    .row_idx        (row_idx),
    .row_last       (row_last),
    .busy           (busy),
    .done           (done),
    .cycles_latched (cycles_latched),
    .overrun        (overrun),
    .dbg_state      (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] elem(input int r, input int c, input logic [15:0] salt);
    logic [3:0] rn;
    logic [3:0] cn;
    rn = 4'(r);
    cn = 4'(c);
    return {rn, cn, 8'h00} ^ salt;
  endfunction

  function automatic logic [ROWS*COLS*OPW-1:0] mk_mat(input logic [15:0] salt);
    logic [ROWS*COLS*OPW-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[(r*COLS+c)*OPW +: OPW] = elem(r, c, salt);
    return m;
  endfunction

  function automatic logic [COLS*OPW-1:0] exp_row(input int r, input logic [15:0] salt);
    logic [COLS*OPW-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*OPW +: OPW] = elem(r, c, salt);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0,... per valid cycle
  task automatic run_stream(input logic [15:0] salt, input int start, input int mode, input string tag);
    int exp_i;
    int k;
    bit done_seen;
    exp_i = start;
    k = 0;
    done_seen = 1'b0;
    for (int n = 0; n < 40 && !done_seen; n++) begin
      tick();
      if (done) begin
        done_seen = 1'b1;
        check({tag, "_valid_in_done"}, 64'(row_valid), 64'd0);
      end else if (row_valid) begin
        check({tag, "_idx"}, 64'(row_idx), 64'(exp_i));
        check({tag, "_data"}, row_data, exp_row(exp_i, salt));
        check({tag, "_last"}, 64'(row_last), 64'(exp_i == ROWS-1));
        row_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
        k++;
        if (row_ready) exp_i++;
      end
    end
    check({tag, "_rows_delivered"}, 64'(exp_i), 64'(ROWS));
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    row_ready = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    rst = 1'b0;
    clr = 1'b0;
    compute_done = 1'b0;
    cycles_count = 32'd37;
    output_matrix = mk_mat(16'h0000);
    row_ready = 1'b0;
    #3;
    check("rst_valid", 64'(row_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cycles", 64'(cycles_latched), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic run: exact latency, ready held high
    compute_done = 1'b1;
    tick();
    check("b_capture_busy", 64'(busy), 64'd1);
    check("b_capture_valid", 64'(row_valid), 64'd0);
    tick();
    check("b_first_valid", 64'(row_valid), 64'd1);
    check("b_row0_idx", 64'(row_idx), 64'd0);
    check("b_row0_data", row_data, exp_row(0, 16'h0000));
    check("b_row0_last", 64'(row_last), 64'd0);
    row_ready = 1'b1;
    for (int r = 1; r < ROWS; r++) begin
      tick();
      check("b_row_valid", 64'(row_valid), 64'd1);
      check("b_row_idx", 64'(row_idx), 64'(r));
      check("b_row_data", row_data, exp_row(r, 16'h0000));
      check("b_row_last", 64'(row_last), 64'(r == ROWS-1));
    end
    check("b_c23", 64'(row_data[3*OPW +: OPW]), 64'h3300);
    tick();
    check("b_done", 64'(done), 64'd1);
    check("b_done_valid", 64'(row_valid), 64'd0);
    check("b_done_busy", 64'(busy), 64'd1);
    tick();
    check("b_done_pulse_end", 64'(done), 64'd0);
    check("b_idle_busy", 64'(busy), 64'd0);
    check("b_cycles", 64'(cycles_latched), 64'd37);
    row_ready = 1'b0;

    // Held level: compute_done stays high, no second capture
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("held_no_recapture", 64'(busy_cnt), 64'd0);
    compute_done = 1'b0;
    tick();
    output_matrix = mk_mat(16'h0011);
    cycles_count = 32'd50;
    compute_done = 1'b1;
    run_stream(16'h0011, 0, 0, "held_restream");
    check("held_cycles", 64'(cycles_latched), 64'd50);

    // Overrun: second rise during row 1
    compute_done = 1'b0;
    tick();
    output_matrix = mk_mat(16'h00A5);
    compute_done = 1'b1;
    tick();
    tick();
    check("ov_row0_idx", 64'(row_idx), 64'd0);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    check("ov_row1_idx", 64'(row_idx), 64'd1);
    output_matrix = mk_mat(16'h5A00);
    compute_done = 1'b0;
    tick();
    check("ov_before_rise", 64'(overrun), 64'd0);
    compute_done = 1'b1;
    tick();
    check("ov_set", 64'(overrun), 64'd1);
    check("ov_hold_idx", 64'(row_idx), 64'd1);
    check("ov_hold_data", row_data, exp_row(1, 16'h00A5));
    run_stream(16'h00A5, 1, 0, "ov_stream");
    tick();
    check("ov_sticky", 64'(overrun), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ov_cleared", 64'(overrun), 64'd0);

    // clr mid-stream at row 2
    compute_done = 1'b0;
    tick();
    output_matrix = mk_mat(16'h0C0C);
    compute_done = 1'b1;
    row_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("clr_at_row2", 64'(row_idx), 64'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    row_ready = 1'b0;
    check("clr_valid", 64'(row_valid), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_idx", 64'(row_idx), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("clr_no_done", 64'(done_cnt), 64'd0);

    // clr together with a rise: clr wins, and a held level afterwards does not capture
    compute_done = 1'b0;
    tick();
    compute_done = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_rise_busy", 64'(busy), 64'd0);
    tick();
    check("clr_rise_held_busy", 64'(busy), 64'd0);

    // Backpressure stream with fresh data and cycle count
    compute_done = 1'b0;
    tick();
    output_matrix = mk_mat(16'h00D0);
    cycles_count = 32'd1234;
    compute_done = 1'b1;
    run_stream(16'h00D0, 0, 1, "bp");
    check("bp_cycles", 64'(cycles_latched), 64'd1234);

    // Async reset mid-stream between clock edges
    compute_done = 1'b0;
    tick();
    output_matrix = mk_mat(16'h0E0E);
    compute_done = 1'b1;
    tick();
    tick();
    check("ar_valid_before", 64'(row_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", 64'(row_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_idx", 64'(row_idx), 64'd0);
    check("ar_data", row_data, 64'd0);
    check("ar_cycles", 64'(cycles_latched), 64'd0);
    check("ar_done", 64'(done), 64'd0);
    compute_done = 1'b0;
    tick();
    rst = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("ar_no_done", 64'(done_cnt), 64'd0);
    check("ar_stays_idle", 64'(busy_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/os_result_drain.md
OS_RESULT_DRAIN -- requirements
Module: os_result_drain

Interface
REQ-001 Parameter rows, default 64, PE rows of the output-stationary array (minimum 2).
REQ-002 Parameter cols, default 64, PE columns of the array.
REQ-003 Parameter op_width, default 48, accumulator width per PE.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 clr  input  1  synchronous soft abort: return to IDLE and clear overrun.
REQ-007 compute_done  input  1  level done flag from the array.
REQ-008 cycles_count  input  32  array cycle counter, sampled at capture.
REQ-009 output_matrix  input  rows*cols*op_width  flattened C; element (r,c) at bits [(r*cols+c)*op_width +: op_width].
REQ-010 row_valid  output  1  row beat available.
REQ-011 row_ready  input  1  downstream accepts beat.
REQ-012 row_data  output  cols*op_width  captured row; col0 at LSB.
REQ-013 row_idx  output  $clog2(rows)  index of current row.
REQ-014 row_last  output  1  high with row_valid when row_idx == rows-1.
REQ-015 busy  output  1  high in CAPTURE, STREAM and DONE.
REQ-016 done  output  1  one-cycle pulse after the final beat.
REQ-017 cycles_latched  output  32  cycles_count sampled at capture.
REQ-018 overrun  output  1  sticky: compute_done rose while not IDLE.

Function
REQ-019 The block SHALL register compute_done (done_q, reset 0) and detect a rise as compute_done && !done_q.
REQ-020 The FSM SHALL have states IDLE, CAPTURE, STREAM, DONE; reset state IDLE.
REQ-021 In IDLE, a rise SHALL load output_matrix into a capture register and cycles_count into cycles_latched, then enter CAPTURE.
REQ-022 CAPTURE SHALL last exactly one cycle, set row_idx = 0, then enter STREAM.
REQ-023 In STREAM, row_valid SHALL be 1, so the first beat is valid 2 cycles after the rise cycle.
REQ-024 row_data SHALL be capture bits [row_idx*cols*op_width +: cols*op_width].
REQ-025 row_valid SHALL stay high and row_data/row_idx stable until row_valid && row_ready.
REQ-026 Valid and no ready SHALL stall indefinitely without change.
REQ-027 On a transfer with row_idx < rows-1, row_idx SHALL increment next cycle; with ready held high, one row is sent per cycle.
REQ-028 On a transfer with row_idx == rows-1, the FSM SHALL enter DONE; row_valid SHALL be 0 in DONE.
REQ-029 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-030 A rise in any non-IDLE state SHALL set overrun, be otherwise ignored, and not disturb capture or stream.
REQ-031 compute_done held high SHALL cause no new capture; only a fresh rise captures.
REQ-032 clr = 1 in any state SHALL force IDLE, row_valid = 0, row_idx = 0 and overrun = 0 next cycle.
REQ-033 When clr and a rise occur together, clr SHALL win and no capture SHALL occur.
REQ-034 done_q SHALL still update during clr cycles.
REQ-035 cycles_latched and the capture register SHALL hold until the next capture.
REQ-036 The block SHALL not modify data: widths pass through, with no truncation or sign handling.

Reset
REQ-037 rst low SHALL clear asynchronously: FSM = IDLE, row_valid = 0, done = 0, busy = 0, overrun = 0, row_idx = 0, done_q = 0, cycles_latched = 0, capture register = 0.
REQ-038 Reset during STREAM SHALL abort the stream; no done pulse follows.

Structure
REQ-039 Shared package os_pkg SHALL hold the FSM state enum (os_drain_state_t) and a function computing the row-index width from rows.
REQ-040 Rise detection and the done_q register SHALL live in one sub-module, os_edge_detect; the FSM, capture register and row mux SHALL live in the top.

Verification (rows=4, cols=4, op_width=16)
REQ-041 Basic run: C(r,c) = 16'h(r)(c)00 (r, c as hex nibbles, e.g. C(2,3) = 16'h2300), cycles_count = 37, ready held 1 -> rows 0..3 on 4 consecutive cycles with row_last on row 3, done one cycle later, cycles_latched = 37.
REQ-042 Backpressure: ready toggles 1,0,0,1,... -> each row is held stable while ready = 0; all 4 rows are delivered in order with none dropped or repeated.
REQ-043 Overrun: second rise during row 1 -> overrun = 1; the stream still delivers the original data; overrun clears only on clr or reset.
REQ-044 clr mid-stream at row 2 -> row_valid = 0 and busy = 0 next cycle; no done pulse; a later rise captures and streams from row 0.
REQ-045 Held level: compute_done high for 20 cycles -> exactly one capture and one stream; then drop and re-raise -> second stream with the new data.
REQ-046 Async reset asserted mid-stream between clock edges -> outputs are zero immediately, without waiting for a clock edge.
